// File: rtl/ls_size_unit_if.sv
// Bus bundle for ls_size_unit: the request/response handshake plus the data memory port.
// The slave modport is the sizing unit. The master modport is the controller/memory side.
interface ls_size_unit_if #(
  parameter int DATA_W = 32
);
  localparam int LANE_W = $clog2(DATA_W / 8);

  logic              start;
  logic [2:0]        op;
  logic [LANE_W-1:0] addr_lo;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] load_data;
  logic              busy;
  logic              done;
  logic              misaligned;

  modport slave (
    input  start, op, addr_lo, st_data, mem_rdata,
    output mem_rd, mem_wr, mem_wdata, load_data, busy, done, misaligned
  );

  modport master (
    output start, op, addr_lo, st_data, mem_rdata,
    input  mem_rd, mem_wr, mem_wdata, load_data, busy, done, misaligned
  );
endinterface

// File: rtl/ls_size_unit.sv
// Load/store sizing unit: lane select + sign/zero extension for loads, read-modify-write for sub-word stores.
// Optional macro ALIGN_CHECK_EN turns misaligned half/word accesses into faults instead of forcing alignment.
module ls_size_unit #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  ls_size_unit_if.slave  bus
);
  localparam int LANE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = LANE_W + 3;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        op_q;
  logic [LANE_W-1:0] addr_q;
  logic [31:0]       st_q;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_q;
  logic              fault;
  logic              direct_sw;
  logic              is_store;
  logic              mem_rd_s, mem_wr_s, done_s;

  logic [OFF_W-1:0]  byte_off, half_off, word_off;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       lane_w;
  logic [DATA_W-1:0] extended;
  logic [DATA_W-1:0] merged;

  // Only a 32-bit SW covers the whole memory word, so only it can skip the read.
  assign direct_sw = (DATA_W == 32) && (bus.op == OP_SW);
  assign is_store  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

`ifdef ALIGN_CHECK_EN
  logic fault_q;

  always_comb begin
    fault = 1'b0;
    case (bus.op)
      OP_LH, OP_LHU, OP_SH: fault = bus.addr_lo[0];
      OP_LW, OP_SW:         fault = (bus.addr_lo[1:0] != 2'b00);
      default:              fault = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_q <= 1'b0;
    else if (state == IDLE && bus.start)
      fault_q <= fault;
  end

  assign bus.misaligned = done_s & fault_q;
`else
  assign fault          = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    done_s     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (fault)
            state_next = DONE;
          else if (direct_sw)
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD: begin
        mem_rd_s   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1)
          state_next = is_store ? WR : DONE;
      end
      WR: begin
        mem_wr_s   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_s     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifting the offset right before scaling drops the low address bits, which gives forced alignment for free.
  assign byte_off = OFF_W'(addr_q) << 3;
  assign half_off = OFF_W'(addr_q >> 1) << 4;
  assign word_off = OFF_W'(addr_q >> 2) << 5;

  assign lane_b = bus.mem_rdata[byte_off +: 8];
  assign lane_h = bus.mem_rdata[half_off +: 16];
  assign lane_w = bus.mem_rdata[word_off +: 32];

  // Over-replicate the sign bit and truncate, so the 32-bit LW case needs no zero-width replication.
  always_comb begin
    extended = '0;
    case (op_q)
      OP_LB:   extended = DATA_W'({{DATA_W{lane_b[7]}}, lane_b});
      OP_LBU:  extended = DATA_W'(lane_b);
      OP_LH:   extended = DATA_W'({{DATA_W{lane_h[15]}}, lane_h});
      OP_LHU:  extended = DATA_W'(lane_h);
      OP_LW:   extended = DATA_W'({{DATA_W{lane_w[31]}}, lane_w});
      default: extended = '0;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    case (op_q)
      OP_SB:   merged[byte_off +: 8]  = st_q[7:0];
      OP_SH:   merged[half_off +: 16] = st_q[15:0];
      default: merged[word_off +: 32] = st_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      st_q    <= '0;
      cnt     <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            addr_q <= bus.addr_lo;
            st_q   <= bus.st_data[31:0];
            if (direct_sw && !fault)
              wdata_q <= bus.st_data;
          end
        end
        RD: cnt <= 3'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (is_store)
              wdata_q <= merged;
            else
              load_q  <= extended;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd    = mem_rd_s;
  assign bus.mem_wr    = mem_wr_s;
  assign bus.mem_wdata = wdata_q;
  assign bus.load_data = load_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_s;
endmodule

// File: tb/tb_ls_size_unit.sv
// Scoreboard bench for ls_size_unit: a 32-bit/MEM_LAT=1 instance and a 64-bit/MEM_LAT=3 instance,
// each fed by a memory model that presents valid read data only in the cycle the latency allows.
module tb_ls_size_unit;
  localparam int LAT32 = 1;
  localparam int LAT64 = 3;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [63:0] load;
    logic        mis;
    logic [63:0] wdata;
    int          rd_at;
    int          wr_at;
    int          done_at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ls_size_unit_if #(.DATA_W(32)) b32();
  ls_size_unit_if #(.DATA_W(64)) b64();

  ls_size_unit #(.DATA_W(32), .MEM_LAT(LAT32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  ls_size_unit #(.DATA_W(64), .MEM_LAT(LAT64)) dut64 (.clk(clk), .reset(reset), .bus(b64));

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          sel = 1'b0;
  logic [63:0] mem_word = '0;
  logic [63:0] ld32 = '0;
  logic [63:0] ld64 = '0;
  logic [7:0]  pipe32, pipe64;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: correct data only MEM_LAT cycles after the read strobe, inverted data otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe32 <= '0;
      pipe64 <= '0;
    end else begin
      pipe32 <= {pipe32[6:0], b32.mem_rd};
      pipe64 <= {pipe64[6:0], b64.mem_rd};
    end
  end
  assign b32.mem_rdata = pipe32[LAT32-1] ? mem_word[31:0] : ~mem_word[31:0];
  assign b64.mem_rdata = pipe64[LAT64-1] ? mem_word : ~mem_word;

  logic        v_rd, v_wr, v_done, v_busy, v_mis;
  logic [63:0] v_wdata, v_load;
  always_comb begin
    if (sel) begin
      v_rd = b64.mem_rd; v_wr = b64.mem_wr; v_done = b64.done; v_busy = b64.busy;
      v_mis = b64.misaligned; v_wdata = b64.mem_wdata; v_load = b64.load_data;
    end else begin
      v_rd = b32.mem_rd; v_wr = b32.mem_wr; v_done = b32.done; v_busy = b32.busy;
      v_mis = b32.misaligned; v_wdata = {32'b0, b32.mem_wdata}; v_load = {32'b0, b32.load_data};
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference behaviour built from byte offsets and masks.
  function automatic exp_t model(input int dw, input int lat, input logic [2:0] op, input int a,
                                 input logic [63:0] st, input logic [63:0] mem, input logic [63:0] prev);
    exp_t e;
    int size, base;
    bit store, sgn, fault;
    logic [63:0] dmask, lmask, lane;
    store = (op >= 3'd5);
    sgn   = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
    case (op)
      3'd0, 3'd1, 3'd5: size = 1;
      3'd2, 3'd3, 3'd6: size = 2;
      default:          size = 4;
    endcase
    fault = ALIGN && ((a % size) != 0);
    base  = a - (a % size);
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    lmask = (64'd1 << (8 * size)) - 64'd1;
    e.load = prev; e.mis = fault; e.wdata = '0; e.rd_at = 0; e.wr_at = 0; e.done_at = 0;
    if (fault) begin
      e.done_at = 1;
    end else if (op == 3'd7 && dw == 32) begin
      e.wr_at = 1; e.wdata = st & dmask; e.done_at = 2;
    end else begin
      e.rd_at = 1;
      lane = (mem >> (8 * base)) & lmask;
      if (store) begin
        e.wdata = ((mem & ~(lmask << (8 * base))) | ((st & lmask) << (8 * base))) & dmask;
        e.wr_at = lat + 2; e.done_at = lat + 3;
      end else begin
        if (sgn && lane[8 * size - 1]) lane = lane | ~lmask;
        e.load = lane & dmask; e.done_at = lat + 2;
      end
    end
    return e;
  endfunction

  // Monitor: follows the selected DUT and pops one expectation per done pulse.
  int          rd_at = 0, wr_at = 0, rd_n = 0, wr_n = 0;
  logic [63:0] wd_seen = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_at = 0; wr_at = 0; rd_n = 0; wr_n = 0; wd_seen = '0;
    end else begin
      if (v_rd) begin rd_n++; rd_at = cyc - start_cyc; end
      if (v_wr) begin wr_n++; wr_at = cyc - start_cyc; wd_seen = v_wdata; end
      if (v_done) begin
        checkOutput("sb_pop", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          checkOutput("done_cycle", 64'(cyc - start_cyc), 64'(e.done_at));
          checkOutput("rd_cycle", 64'(rd_at), 64'(e.rd_at));
          checkOutput("rd_count", 64'(rd_n), 64'(e.rd_at != 0));
          checkOutput("wr_cycle", 64'(wr_at), 64'(e.wr_at));
          checkOutput("wr_count", 64'(wr_n), 64'(e.wr_at != 0));
          if (e.wr_at != 0) checkOutput("mem_wdata", wd_seen, e.wdata);
          checkOutput("load_data", v_load, e.load);
          checkOutput("misaligned", 64'(v_mis), 64'(e.mis));
          checkOutput("busy_in_done", 64'(v_busy), 64'd1);
        end
        rd_at = 0; wr_at = 0; rd_n = 0; wr_n = 0; wd_seen = '0;
      end
    end
  end

  task automatic driveInputs(input logic [2:0] op, input int a, input logic [63:0] st, input logic s);
    if (sel) begin
      b64.op = op; b64.addr_lo = 3'(a); b64.st_data = st; b64.start = s;
    end else begin
      b32.op = op; b32.addr_lo = 2'(a); b32.st_data = st[31:0]; b32.start = s;
    end
  endtask

  task automatic setStart(input logic s);
    if (sel) b64.start = s; else b32.start = s;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input int a, input logic [63:0] st,
                               input logic [63:0] mem, input bit hold);
    exp_t e;
    bit got;
    e = model(sel ? 64 : 32, sel ? LAT64 : LAT32, op, a, st, mem, sel ? ld64 : ld32);
    if (sel) ld64 = e.load; else ld32 = e.load;
    expq.push_back(e);
    @(negedge clk);
    mem_word = mem;
    driveInputs(op, a, st, 1'b1);
    start_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!hold) setStart(1'b0);
      if (v_done) begin got = 1'b1; setStart(1'b0); end
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    if (!got) expq.delete();
    @(negedge clk);
    checkOutput("idle_after_done", 64'(v_busy), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(v_busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(v_done), 64'd0);
    checkOutput({tag, "_mem_rd"}, 64'(v_rd), 64'd0);
    checkOutput({tag, "_mem_wr"}, 64'(v_wr), 64'd0);
    checkOutput({tag, "_wdata"}, v_wdata, 64'd0);
    checkOutput({tag, "_load"}, v_load, 64'd0);
    checkOutput({tag, "_mis"}, 64'(v_mis), 64'd0);
  endtask

  // SB on the 32-bit unit, aborted by reset while the write strobe is up.
  task automatic resetDuringWrite();
    bit got;
    @(negedge clk);
    mem_word = 64'h0000_0000_5566_7788;
    driveInputs(3'b101, 2, 64'h0000_0000_0000_00CD, 1'b1);
    start_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      setStart(1'b0);
      if (v_wr) got = 1'b1;
    end
    checkOutput("reached_wr", 64'(got), 64'd1);
    reset = 1'b1;
    #1;
    checkResetState("abort");
    ld32 = '0;
    ld64 = '0;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    int          ra;
    logic [63:0] rst_v, rmem;
    reset = 1'b1;
    sel = 1'b1; driveInputs(3'b000, 0, '0, 1'b0);
    sel = 1'b0; driveInputs(3'b000, 0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1 checkResetState("rst32");
    sel = 1'b1;
    #1 checkResetState("rst64");
    sel = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(3'b000, 2, 64'h0000_0000_FFFF_FF12, 64'h0000_0000_1280_3456, 1'b0);
    applyStimulus(3'b011, 2, 64'h0, 64'h0000_0000_8001_1234, 1'b0);
    applyStimulus(3'b010, 2, 64'h0, 64'h0000_0000_8001_1234, 1'b0);
    applyStimulus(3'b101, 1, 64'h0000_0000_1357_9BAB, 64'h0000_0000_1122_3344, 1'b0);
    applyStimulus(3'b111, 0, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0BAD_F00D, 1'b0);
    applyStimulus(3'b100, 1, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0);
    applyStimulus(3'b001, 3, 64'h0, 64'h0000_0000_F0E1_D2C3, 1'b0);
    applyStimulus(3'b110, 3, 64'h0000_0000_0000_A5A5, 64'h0000_0000_1234_5678, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(7, 0)); ra = $urandom_range(3, 0);
      rst_v = {32'b0, $urandom}; rmem = {32'b0, $urandom};
      applyStimulus(rop, ra, rst_v, rmem, 1'b0);
    end
    applyStimulus(3'b101, 2, 64'h0000_0000_0000_0077, 64'h0000_0000_CAFE_BABE, 1'b1);
    resetDuringWrite();
    applyStimulus(3'b000, 0, 64'h0, 64'h0000_0000_0000_007F, 1'b0);

    sel = 1'b1;
    applyStimulus(3'b100, 4, 64'h0, 64'h8765_4321_0000_0001, 1'b0);
    applyStimulus(3'b001, 7, 64'h0, 64'hC3B2_A190_7766_5544, 1'b0);
    applyStimulus(3'b010, 6, 64'h0, 64'h9ABC_1111_2222_3333, 1'b0);
    applyStimulus(3'b111, 4, 64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    applyStimulus(3'b101, 5, 64'h0000_0000_0000_005A, 64'h0123_4567_89AB_CDEF, 1'b0);
    applyStimulus(3'b111, 0, 64'h0000_0000_FACE_B00C, 64'h1111_2222_3333_4444, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(7, 0)); ra = $urandom_range(7, 0);
      rst_v = {$urandom, $urandom}; rmem = {$urandom, $urandom};
      applyStimulus(rop, ra, rst_v, rmem, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
